// File: rtl/twdl_pkg.sv
// Shared types and constants for the twiddle-parameter sequencer.
package twdl_pkg;

    localparam int W_QUO = 20;
    localparam int W_DEN = 12;
    localparam int W_FAC = 3;

    // The phase numerator scale: a full turn is 2^20 in 0.20 fixed point.
    localparam logic [W_QUO:0] PHASE_ONE = 21'h100000;

    // One restoring step per bit of PHASE_ONE.
    localparam logic [4:0] DIV_STEPS = 5'd21;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        RUN,
        FIN
    } state_t;

    typedef struct packed {
        logic [W_FAC-1:0] factor;
        logic [W_DEN-1:0] numrtr;
        logic [W_DEN-1:0] demontr;
        logic [W_QUO-1:0] quotient;
        logic [W_DEN-1:0] remainder;
    } twdl_rec_t;

endpackage

// File: rtl/twdl_recip_div.sv
// Sequential restoring divider producing floor(2^20/D) and 2^20 mod D,
// one quotient bit per cycle over 21 cycles.
module twdl_recip_div
    import twdl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [W_DEN-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [W_QUO-1:0] qs_o,
    output logic [W_DEN-1:0] rs_o
);

    logic [4:0]       count_q, count_d;
    logic [W_DEN-1:0] den_q, den_d;
    logic [W_DEN-1:0] rem_q, rem_d;
    logic [W_QUO-1:0] quo_q, quo_d;
    logic             dividendBit;
    logic [W_DEN:0]   remShift;

    // The dividend is exactly 2^20, so only the first step shifts in a one.
    // The quotient register drops its MSB on each shift: that bit only becomes
    // nonzero for D==1, which the sequencer never sends here.
    always_comb begin
        count_d     = count_q;
        den_d       = den_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dividendBit = (count_q == DIV_STEPS);
        remShift    = {rem_q, dividendBit};
        if (start_i) begin
            count_d = DIV_STEPS;
            den_d   = den_i;
            rem_d   = '0;
            quo_d   = '0;
        end else if (count_q != 5'd0) begin
            count_d = count_q - 5'd1;
            if (remShift >= {1'b0, den_q}) begin
                rem_d = W_DEN'(remShift - {1'b0, den_q});
                quo_d = {quo_q[W_QUO-2:0], 1'b1};
            end else begin
                rem_d = remShift[W_DEN-1:0];
                quo_d = {quo_q[W_QUO-2:0], 1'b0};
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            count_q <= count_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign busy_o = (count_q != 5'd0);
    assign done_o = (count_q == 5'd1);
    assign qs_o   = quo_q;
    assign rs_o   = rem_q;

endmodule

// File: rtl/twdl_param_gen.sv
// Per-stage twiddle-parameter sequencer: one reciprocal division per stage,
// then one {factor, n, D, q, r} record per butterfly under valid/ready.
module twdl_param_gen
    import twdl_pkg::*;
#(
    parameter int wQuo = W_QUO,
    parameter int wDen = W_DEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      cfg_factor,
    input  logic [wDen-1:0] cfg_demontr,
    input  logic [wDen-1:0] cfg_nbfly,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic            out_val,
    input  logic            out_ready,
    output logic [2:0]      factor,
    output logic [wDen-1:0] twdl_numrtr_1,
    output logic [wDen-1:0] twdl_demontr,
    output logic [wQuo-1:0] twdl_quotient,
    output logic [wDen-1:0] twdl_remainder
);

    state_t           state_q, state_d;
    twdl_rec_t        rec_q, rec_d, nextRec;
    logic [W_DEN-1:0] remain_q, remain_d;
    logic             cfgErr_q, cfgErr_d;
    logic [W_DEN-1:0] effDen;
    logic             divStart, divBusy, divDone;
    logic [W_QUO-1:0] divQs;
    logic [W_DEN-1:0] divRs;
    logic [W_DEN:0]   numInc;
    logic [W_DEN:0]   remSum;
    logic [W_DEN-1:0] remAdj;
    logic [W_QUO-1:0] quoSum;

    // A zero denominator is illegal; treat it as 1 so the stage still runs.
    assign effDen = (cfg_demontr == '0) ? W_DEN'(1) : cfg_demontr;

    twdl_recip_div u_recipDiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (divStart),
        .den_i   (effDen),
        .busy_o  (divBusy),
        .done_o  (divDone),
        .qs_o    (divQs),
        .rs_o    (divRs)
    );

    // Step the phase n/D to (n+1)/D by adding the reciprocal, wrapping at n==D.
    always_comb begin
        nextRec = rec_q;
        numInc  = {1'b0, rec_q.numrtr} + (W_DEN+1)'(1);
        remSum  = {1'b0, rec_q.remainder} + {1'b0, divRs};
        quoSum  = rec_q.quotient + divQs;
        remAdj  = remSum[W_DEN-1:0];
        if (remSum >= {1'b0, rec_q.demontr}) begin
            remAdj = W_DEN'(remSum - {1'b0, rec_q.demontr});
            quoSum = quoSum + W_QUO'(1);
        end
        if (numInc == {1'b0, rec_q.demontr}) begin
            nextRec.numrtr    = '0;
            nextRec.quotient  = '0;
            nextRec.remainder = '0;
        end else begin
            nextRec.numrtr    = numInc[W_DEN-1:0];
            nextRec.quotient  = quoSum;
            nextRec.remainder = remAdj;
        end
    end

    // Stage sequencing: accept a start, divide if needed, stream records, finish.
    always_comb begin
        state_d  = state_q;
        rec_d    = rec_q;
        remain_d = remain_q;
        cfgErr_d = cfgErr_q;
        divStart = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rec_d.factor    = cfg_factor;
                    rec_d.numrtr    = '0;
                    rec_d.demontr   = effDen;
                    rec_d.quotient  = '0;
                    rec_d.remainder = '0;
                    remain_d        = cfg_nbfly;
                    cfgErr_d        = (cfg_demontr == '0);
                    if (cfg_nbfly == '0) begin
                        state_d = FIN;
                    end else if (effDen == W_DEN'(1)) begin
                        state_d = RUN;
                    end else begin
                        state_d  = DIV;
                        divStart = 1'b1;
                    end
                end
            end
            DIV: begin
                if (divDone || !divBusy) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    rec_d    = nextRec;
                    remain_d = remain_q - W_DEN'(1);
                    if (remain_q == W_DEN'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rec_q    <= '0;
            remain_q <= '0;
            cfgErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rec_q    <= rec_d;
            remain_q <= remain_d;
            cfgErr_q <= cfgErr_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
    assign out_val        = (state_q == RUN);
    assign cfg_err        = cfgErr_q;
    assign factor         = rec_q.factor;
    assign twdl_numrtr_1  = rec_q.numrtr;
    assign twdl_demontr   = rec_q.demontr;
    assign twdl_quotient  = rec_q.quotient;
    assign twdl_remainder = rec_q.remainder;

endmodule

// File: doc/twdl_param_gen.md
Name: twdl_param_gen

Overview:
- Per-stage twiddle-parameter sequencer for the mixed-radix FFT datapath.
- Emits one parameter record per butterfly into the twiddle-address FIFO; the twiddle multiplier stage later pops these records one per butterfly.
- Each record carries {factor, numerator n, denominator D, quotient, remainder}. The quotient/remainder pair is the 0.20 fixed-point phase n/D that coeff_twdl_CTA consumes.
- A single sequential division runs per stage. Records after the first are produced incrementally, one per cycle, under valid/ready flow control.

Parameters:
- wQuo, 20, quotient width (phase fraction bits).
- wDen, 12, numerator/denominator/remainder/count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; samples cfg_*; ignored while busy
- cfg_factor  in  3  radix of the stage (2..5), passed through to factor
- cfg_demontr  in  12  D, product of previous-stage radices; 0 is illegal
- cfg_nbfly  in  12  number of records to emit (0..4095)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last record handshakes
- cfg_err  out  1  sticky; set when D==0 is accepted; cleared by the next accepted start with D!=0
- out_val  out  1  record valid
- out_ready  in  1  FIFO not almost-full
- factor  out  3  record radix
- twdl_numrtr_1  out  12  n
- twdl_demontr  out  12  D
- twdl_quotient  out  20  floor(n*2^20/D)
- twdl_remainder  out  12  (n*2^20) mod D

Behaviour:
- Reset: every output is 0. State goes to IDLE. Reset mid-operation aborts the stage, and no done pulse is produced.
- States:
  - IDLE: on start, latch cfg_*; if cfg_demontr==0, use D=1 and set cfg_err.
    - If nbfly==0, go to FIN.
    - If D==1, go to RUN with qs=0, rs=0.
    - Otherwise go to DIV.
  - DIV: restoring division of 2^20 by D, one quotient bit per cycle, exactly 21 cycles. Result is qs=floor(2^20/D), rs=2^20 mod D. Then go to RUN.
  - RUN: present records; leave for FIN on the handshake of record nbfly-1.
  - FIN: assert done for 1 cycle, go to IDLE.
- Latency (start in cycle T):
  - DIV case: first out_val at T+22.
  - D==1 case: first out_val at T+1.
  - nbfly==0 case: done at T+1.
- Handshake:
  - A record transfers when out_val && out_ready.
  - While out_val && !out_ready, all record fields hold stable.
  - out_val never drops without a transfer.
  - In RUN, out_val stays high every cycle until the last transfer. Throughput is 1 record/cycle when ready is held high.
- Incremental update on each transfer:
  - n' = n+1; q' = q+qs; r' = r+rs, computed 13 bits wide.
  - If r' >= D: r' -= D and q' += 1.
  - If n+1 == D (wrap): n, q and r all restart at 0.
- First record in a stage: n=0, q=0, r=0.
- Widths: q < 2^20 always holds because n < D. With D==1, n stays 0 and q=r=0, so the 2^20 overflow never arises.
- Simultaneous start and last transfer: start is ignored, because busy is still high.
- busy is low in IDLE only.
- done and the last transfer never occur in the same cycle; done follows one cycle later.

Decomposition:
- Shared package twdl_pkg:
  - constants W_QUO=20, W_DEN=12, PHASE_ONE=2^20;
  - enum state_t {IDLE, DIV, RUN, FIN};
  - packed struct twdl_rec_t {factor, numrtr, demontr, quotient, remainder}.
- One sub-module: twdl_recip_div.
  - Sequential restoring divider for 2^20/D.
  - Interface: start/busy/done, output qs and rs.
  - The FSM, counters and incremental accumulator stay in twdl_param_gen.

Test Plan:
- D=5, nbfly=7, factor=3, ready=1:
  - n = 0,1,2,3,4,0,1;
  - q = 0, 209715, 419430, 629145, 838860, 0, 209715;
  - r = 0,1,2,3,4,0,1;
  - first out_val at T+22, done at the cycle after the 7th transfer.
- D=7, nbfly=3: qs=149796, rs=4; records (n,q,r) = (0,0,0), (1,149796,4), (2,299593,1). This checks the remainder carry.
- D=1, nbfly=4: out_val at T+1; four records with n=q=r=0; no DIV cycles.
- D=3, nbfly=3, out_ready toggling 1,0,0,1,…: fields hold during stalls; records are (0,0,0), (1,349525,1), (2,699050,2), in order with none dropped.
- nbfly=0: done at T+1 and no out_val. Then D=0 with nbfly=2: cfg_err=1, two records with n=q=r=0.
- rst_n low during RUN after 2 transfers: next cycle all outputs are 0 and no done pulse. A new start then produces a full correct sequence; a start pulsed while busy is ignored.
